// File: rtl/btb_assoc_predictor_pkg.sv
// rtl/btb_assoc_predictor_pkg.sv - shared counter encodings, entry layout and counter helper for the BTB
package btb_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_INIT_DEF = WT;

    localparam int DEF_TAG_W = 4;
    localparam int DEF_TGT_W = 30;

    // Entry layout at the default widths; the predictor builds its own copy at its widths
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_TGT_W-1:0] target;
        logic [1:0]           cnt;
    } btb_entry_t;

    // Two-bit saturating counter step toward the resolved direction
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_predictor_if.sv
// rtl/btb_assoc_predictor_if.sv - fetch/resolve signal bundle between pipeline and BTB
interface btb_assoc_predictor_if;
    logic        stall_i;
    logic [31:0] if_pc_i;
    logic [31:0] ex_pc_i;
    logic        ex_is_branch_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic        pred_taken_o;
    logic [31:0] next_pc_o;
    logic        flush_o;

    modport master (
        output stall_i, if_pc_i, ex_pc_i, ex_is_branch_i, ex_taken_i,
               ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        input  pred_taken_o, next_pc_o, flush_o
    );

    modport slave (
        input  stall_i, if_pc_i, ex_pc_i, ex_is_branch_i, ex_taken_i,
               ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        output pred_taken_o, next_pc_o, flush_o
    );
endinterface

// File: rtl/btb_assoc_predictor_victim_sel.sv
// rtl/btb_assoc_predictor_victim_sel.sv - replacement way choice: first invalid way, else LRU way
module btb_victim_sel #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-1:0] valid,
    input  logic            lru,
    output logic            victim
);

    if (WAYS == 1) begin : g_direct
        logic unused_sel;
        assign unused_sel = ^{valid, lru};
        assign victim     = 1'b0;
    end else begin : g_two_way
        // Fill empty ways before evicting anything live
        always_comb begin
            if (!valid[0]) begin
                victim = 1'b0;
            end else if (!valid[1]) begin
                victim = 1'b1;
            end else begin
                victim = lru;
            end
        end
    end

endmodule

// File: rtl/btb_assoc_predictor.sv
// rtl/btb_assoc_predictor.sv - set-associative BTB with 2-bit counters; BTB_PERF_EN adds perf counters
module btb_assoc_predictor
    import btb_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         WAYS     = 2,
    parameter int         TAG_W    = 4,
    parameter int         TGT_W    = 30,
    parameter logic [1:0] CNT_INIT = CNT_INIT_DEF
) (
    input logic                clk,
    input logic                rst_n,
    btb_assoc_predictor_if.slave bus
`ifdef BTB_PERF_EN
    ,
    output logic [31:0]        perf_hits_o,
    output logic [31:0]        perf_branches_o,
    output logic [31:0]        perf_mispred_o
`endif
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        logic [1:0]       cnt;
    } entry_t;

    entry_t          tbl [SETS][WAYS];
    logic [SETS-1:0] lru;   // per set: index of the least recently used way

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             if_way;
    logic [TGT_W-1:0] hit_tgt;
    logic [31:0]      pred_tgt;
    logic             pred_taken;
    logic             mis;

    logic             upd_v;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_taken;
    logic [TGT_W-1:0] upd_tgt;
    logic             u_hit;
    logic             u_way;
    logic [WAYS-1:0]  u_valid;
    logic             victim;

    assign if_idx = bus.if_pc_i[IDX_W+1:2];
    assign if_tag = bus.if_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch lookup; scanning downward lets way0 win when both ways match
    always_comb begin
        if_hit = 1'b0;
        if_way = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tbl[if_idx][w[0]].valid && tbl[if_idx][w[0]].tag == if_tag) begin
                if_hit = 1'b1;
                if_way = w[0];
            end
        end
    end

    assign hit_tgt    = tbl[if_idx][if_way].target;
    assign pred_taken = if_hit & tbl[if_idx][if_way].cnt[1];

    if (TGT_W == 30) begin : g_full_tgt
        assign pred_tgt = {hit_tgt, 2'b00};
    end else begin : g_part_tgt
        assign pred_tgt = {bus.if_pc_i[31:TGT_W+2], hit_tgt, 2'b00};
    end

    assign mis = bus.ex_is_branch_i &
                 ((bus.ex_taken_i != bus.ex_pred_taken_i) |
                  (bus.ex_taken_i & bus.ex_pred_taken_i &
                   (bus.ex_target_i != bus.ex_pred_target_i)));

    assign bus.pred_taken_o = pred_taken;
    assign bus.flush_o      = mis;

    // EX redirect has priority over the fetch-side prediction
    always_comb begin
        if (mis) begin
            bus.next_pc_o = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
        end else if (pred_taken) begin
            bus.next_pc_o = pred_tgt;
        end else begin
            bus.next_pc_o = bus.if_pc_i + 32'd4;
        end
    end

    // Re-lookup of the registered update PC against the live table
    always_comb begin
        u_hit   = 1'b0;
        u_way   = 1'b0;
        u_valid = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            u_valid[w] = tbl[upd_idx][w[0]].valid;
            if (tbl[upd_idx][w[0]].valid && tbl[upd_idx][w[0]].tag == upd_tag) begin
                u_hit = 1'b1;
                u_way = w[0];
            end
        end
    end

    btb_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .valid  (u_valid),
        .lru    (lru[upd_idx]),
        .victim (victim)
    );

    // Capture resolved branches and apply the previous cycle's capture to the table
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_v <= 1'b0;
            lru   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tbl[s[IDX_W-1:0]][w[0]].valid <= 1'b0;
                    tbl[s[IDX_W-1:0]][w[0]].cnt   <= SNT;
                end
            end
        end else begin
            upd_v     <= bus.ex_is_branch_i & ~bus.stall_i;
            upd_idx   <= bus.ex_pc_i[IDX_W+1:2];
            upd_tag   <= bus.ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
            upd_taken <= bus.ex_taken_i;
            upd_tgt   <= bus.ex_target_i[TGT_W+1:2];
            if (upd_v) begin
                if (u_hit) begin
                    if (upd_taken && tbl[upd_idx][u_way].target != upd_tgt) begin
                        tbl[upd_idx][u_way].target <= upd_tgt;
                        tbl[upd_idx][u_way].cnt    <= CNT_INIT;
                    end else begin
                        tbl[upd_idx][u_way].cnt <= sat_next(tbl[upd_idx][u_way].cnt, upd_taken);
                    end
                    lru[upd_idx] <= ~u_way;
                end else if (upd_taken) begin
                    tbl[upd_idx][victim] <= entry_t'{1'b1, upd_tag, upd_tgt, CNT_INIT};
                    lru[upd_idx]         <= ~victim;
                end
            end
        end
    end

`ifdef BTB_PERF_EN
    // Event counters, frozen during memory stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_hits_o     <= '0;
            perf_branches_o <= '0;
            perf_mispred_o  <= '0;
        end else if (!bus.stall_i) begin
            if (if_hit)             perf_hits_o     <= perf_hits_o + 32'd1;
            if (bus.ex_is_branch_i) perf_branches_o <= perf_branches_o + 32'd1;
            if (mis)                perf_mispred_o  <= perf_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// tb/tb_btb_assoc_predictor.sv - scoreboard bench for btb_assoc_predictor
module tb_btb_assoc_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    btb_assoc_predictor_if bus();

    btb_assoc_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc;
        logic        br;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] etgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        st;
        logic        xp;
        logic [31:0] xn;
        logic        xf;
    } row_t;

    typedef struct {
        logic        pred;
        logic [31:0] npc;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(input logic [31:0] ipc, input logic br, input logic [31:0] epc,
                                input logic tk, input logic [31:0] etgt, input logic ptk,
                                input logic [31:0] ptgt, input logic st,
                                input logic xp, input logic [31:0] xn, input logic xf);
        row_t r;
        r.ipc = ipc; r.br = br; r.epc = epc; r.tk = tk; r.etgt = etgt;
        r.ptk = ptk; r.ptgt = ptgt; r.st = st; r.xp = xp; r.xn = xn; r.xf = xf;
        return r;
    endfunction

    function automatic row_t idle(input logic [31:0] ipc, input logic xp, input logic [31:0] xn);
        return mk(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, xp, xn, 1'b0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input row_t r);
        exp_t e;
        bus.if_pc_i          = r.ipc;
        bus.ex_is_branch_i   = r.br;
        bus.ex_pc_i          = r.epc;
        bus.ex_taken_i       = r.tk;
        bus.ex_target_i      = r.etgt;
        bus.ex_pred_taken_i  = r.ptk;
        bus.ex_pred_target_i = r.ptgt;
        bus.stall_i          = r.st;
        e.pred  = r.xp;
        e.npc   = r.xn;
        e.flush = r.xf;
        sb.push_back(e);
    endtask

    task automatic do_reset;
        tick();
        rst_n = 1'b0;
        apply(idle(32'h0, 1'b0, 32'h4));
        void'(sb.pop_back());
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        row_t rows[$];
        exp_t e;
        rst_n = 1'b0;
        tick();
        tick();
        apply(idle(32'h40, 1'b0, 32'h44));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
            errors++;
            $display("FAIL reset_hold got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                     bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
        end
        rst_n = 1'b1;
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        rows.push_back(mk(32'h80, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h84, 1'b0));
        rows.push_back(idle(32'hFFFF_FFFC, 1'b0, 32'h0));
        rows.push_back(mk(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1));
        rows.push_back(idle(32'h0, 1'b0, 32'h4));
        foreach (rows[i]) begin
            tick();
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
                errors++;
                $display("FAIL reset[%0d] got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                         i, bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
            end
        end
    endtask

    task automatic test_alloc_and_decay;
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        rows.push_back(idle(32'h40, 1'b1, 32'h100));
        rows.push_back(mk(32'h300, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44, 1'b1));
        rows.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        rows.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        foreach (rows[i]) begin
            tick();
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
                errors++;
                $display("FAIL alloc_decay[%0d] got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                         i, bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
            end
        end
    endtask

    task automatic test_lru;
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1));
        rows.push_back(mk(32'h0, 1'b1, 32'h60, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1));
        rows.push_back(mk(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h4, 1'b0));
        rows.push_back(mk(32'h0, 1'b1, 32'h80, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h108, 1'b1));
        rows.push_back(idle(32'h0, 1'b0, 32'h4));
        rows.push_back(idle(32'h40, 1'b1, 32'h100));
        rows.push_back(idle(32'h80, 1'b1, 32'h108));
        rows.push_back(idle(32'h60, 1'b0, 32'h64));
        foreach (rows[i]) begin
            tick();
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
                errors++;
                $display("FAIL lru[%0d] got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                         i, bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
            end
        end
    endtask

    task automatic test_target_fix;
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1));
        rows.push_back(mk(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h4, 1'b0));
        rows.push_back(idle(32'h0, 1'b0, 32'h4));
        rows.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b0, 1'b1, 32'h180, 1'b1));
        rows.push_back(idle(32'h40, 1'b1, 32'h100));
        rows.push_back(idle(32'h40, 1'b1, 32'h180));
        rows.push_back(mk(32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h180, 1'b0, 1'b0, 32'h44, 1'b1));
        rows.push_back(idle(32'h0, 1'b0, 32'h4));
        rows.push_back(idle(32'h40, 1'b0, 32'h44));
        foreach (rows[i]) begin
            tick();
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
                errors++;
                $display("FAIL target_fix[%0d] got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                         i, bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
            end
        end
    endtask

    task automatic test_back_to_back;
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(32'h0, 1'b1, 32'h50, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b1));
        rows.push_back(idle(32'h50, 1'b0, 32'h54));
        rows.push_back(idle(32'h50, 1'b0, 32'h54));
        rows.push_back(mk(32'h0, 1'b1, 32'h50, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h200, 1'b1));
        rows.push_back(mk(32'h0, 1'b1, 32'h70, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 1'b1));
        rows.push_back(idle(32'h0, 1'b0, 32'h4));
        rows.push_back(idle(32'h50, 1'b1, 32'h200));
        rows.push_back(idle(32'h70, 1'b1, 32'h300));
        foreach (rows[i]) begin
            tick();
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
                errors++;
                $display("FAIL back_to_back[%0d] got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                         i, bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
            end
        end
    endtask

    task automatic test_reset_mid_update;
        exp_t e;
        do_reset();
        tick();
        apply(mk(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
            errors++;
            $display("FAIL reset_mid_alloc got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                     bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
        end
        tick();
        rst_n = 1'b0;
        apply(idle(32'h40, 1'b0, 32'h44));
        void'(sb.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        apply(idle(32'h40, 1'b0, 32'h44));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.pred_taken_o, bus.next_pc_o, bus.flush_o} !== {e.pred, e.npc, e.flush}) begin
            errors++;
            $display("FAIL reset_mid_discard got pred=%b npc=%h flush=%b exp pred=%b npc=%h flush=%b",
                     bus.pred_taken_o, bus.next_pc_o, bus.flush_o, e.pred, e.npc, e.flush);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bus.stall_i          = 1'b0;
        bus.if_pc_i          = 32'h0;
        bus.ex_pc_i          = 32'h0;
        bus.ex_is_branch_i   = 1'b0;
        bus.ex_taken_i       = 1'b0;
        bus.ex_target_i      = 32'h0;
        bus.ex_pred_taken_i  = 1'b0;
        bus.ex_pred_target_i = 32'h0;
        test_reset();
        test_alloc_and_decay();
        test_lru();
        test_target_fix();
        test_back_to_back();
        test_reset_mid_update();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_assoc_predictor.md
Name: btb_assoc_predictor

Overview:
Parametrised, optionally 2-way set-associative branch target buffer with 2-bit saturating counters. It sits beside the IF stage: it predicts taken/target for the fetch PC combinationally. Branches resolved in EX update it through a one-cycle registered update stage.
It generalises entry count, tag width, target width and associativity, adds LRU replacement, and gives a correct fall-through redirect on a not-taken mispredict.

Parameters:
ENTRIES, 16, total entries; power of 2, at least 2*WAYS
WAYS, 2, associativity; 1 or 2 only
TAG_W, 4, stored tag bits
TGT_W, 30, stored target bits = pc[TGT_W+1:2]; 1..30
CNT_INIT, 2'b10, counter value on allocate or target correction

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall_i  in  1  pipeline memory stall; suppresses capture of EX update
if_pc_i  in  32  fetch PC
ex_pc_i  in  32  PC of instruction in EX
ex_is_branch_i  in  1  EX holds a branch/jump
ex_taken_i  in  1  resolved direction
ex_target_i  in  32  resolved taken target
ex_pred_taken_i  in  1  prediction carried with the instruction
ex_pred_target_i  in  32  predicted target carried with the instruction
pred_taken_o  out  1  IF prediction
next_pc_o  out  32  PC to fetch next
flush_o  out  1  EX mispredict; flush IF/ID

Behaviour:
- Geometry: SETS=ENTRIES/WAYS; IDX_W=log2(SETS); index=pc[IDX_W+1:2]; tag=pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, target[TGT_W-1:0], cnt[1:0]. Each set holds one LRU bit when WAYS=2.
- Lookup (combinational): hit = valid & tag match in any way. If both ways match, way0 wins.
- pred_taken_o = hit & cnt[1].
- Predicted target = {if_pc_i[31:TGT_W+2], target, 2'b00}.
- Mispredict (combinational, independent of stall_i): mis = ex_is_branch_i & ((ex_taken_i != ex_pred_taken_i) | (ex_taken_i & ex_pred_taken_i & ex_target_i != ex_pred_target_i)).
- flush_o = mis.
- next_pc_o: if mis, ex_taken_i ? ex_target_i : ex_pc_i+4. Else if pred_taken_o, the predicted target. Else if_pc_i+4. All arithmetic is modulo 2^32.
- Update capture: at a clk edge with ex_is_branch_i & !stall_i, register pc, taken and target, and set upd_v=1. Otherwise upd_v=0.
- Update write (the cycle after capture): re-look up the registered PC against the current table, so back-to-back updates to the same set never see stale data.
- Hit, taken, stored target != resolved target: overwrite target, cnt=CNT_INIT.
- Hit, otherwise: saturating count, +1 if taken, -1 if not, clamped at 00/11.
- Miss and taken: allocate the first invalid way (way0 first), else the LRU way. Write valid=1, tag, target, cnt=CNT_INIT.
- Miss and not taken: no change.
- Any hit or allocate makes the touched way MRU.
- A lookup in the same cycle as a write sees pre-write contents. No bypass.
- Reset: all valid, cnt, LRU and upd_v cleared. pred_taken_o=0, flush_o=0, next_pc_o=if_pc_i+4. Reset mid-update discards the pending write.

Optional Feature:
- Macro BTB_PERF_EN.
- Defined: adds outputs perf_hits_o[31:0] (counts IF lookups that hit), perf_branches_o[31:0] (counts captured updates) and perf_mispred_o[31:0] (counts cycles with flush_o & !stall_i). All three wrap, are cleared by reset, and are frozen while stall_i=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package btb_pkg holds: counter encoding constants (SNT=00, WNT=01, WT=10, ST=11), default CNT_INIT, function sat_next(cnt, taken), and the entry struct typedef parametrised by width localparams.
- Sub-module btb_victim_sel: inputs valid[WAYS-1:0] and lru; output is the victim way. For WAYS=1 it tie-offs to way0.

Test Plan:
- Reset, then if_pc_i=0x40 → pred_taken_o=0, next_pc_o=0x44, flush_o=0.
- EX: pc 0x40 taken to 0x100, pred_taken=0 → same cycle flush_o=1, next_pc_o=0x100. Two cycles later if_pc_i=0x40 → pred_taken_o=1, next_pc_o=0x100.
- After the above, resolve 0x40 not-taken twice (pred_taken=1 first time) → first: flush_o=1, next_pc_o=0x44; cnt 10→01→00; later lookup of 0x40 gives pred_taken_o=0.
- 2-way LRU on set 0: allocate 0x40 (tag 2), then 0x60 (tag 3), then hit-update 0x40, then allocate 0x80 (tag 4) → 0x60 evicted; 0x40 and 0x80 hit, 0x60 misses.
- Entry 0x40→0x100, resolve taken to 0x180 with pred target 0x100 → flush_o=1, next_pc_o=0x180; later lookup predicts 0x180, cnt=10.
- stall_i=1 while resolving a taken miss at 0x50 → flush_o=1, but no allocation; 0x50 still misses. Back-to-back updates to the same set both land.
